// File: rtl/rdload_pkg.sv
// ---------------------------------------------------------------------------
// rdload_pkg
// Shared definitions for the load controller slice:
//   - size_e   : access-size encodings carried on req_size
//   - state_e  : controller FSM state encodings
//   - cnt_width: width of the response-timeout counter for a given TIMEOUT
//   - req_is_bad: classifies a request as misaligned or illegal
// ---------------------------------------------------------------------------
package rdload_pkg;

  // Access size as presented on req_size.
  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  // Controller states; IDLE is the reset state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // The counter keeps counting on the final WAIT cycle, so it must be able
  // to hold TIMEOUT itself, not just TIMEOUT-1.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // A request is rejected without touching the bus when its size is illegal
  // or its byte offset is not a multiple of the access size.
  function automatic logic req_is_bad(input size_e size, input logic [1:0] lane);
    logic bad_s;
    bad_s = 1'b1;
    case (size)
      SIZE_BYTE: bad_s = 1'b0;
      SIZE_HALF: bad_s = lane[0];
      SIZE_WORD: bad_s = (lane != 2'b00);
      default:   bad_s = 1'b1;
    endcase
    return bad_s;
  endfunction

endpackage

// File: rtl/rdload_if.sv
// ---------------------------------------------------------------------------
// rdload_if
// Bundles the three handshakes of the load controller:
//   req_*     : load request from the core (valid/ready, addr, size, signed)
//   bus_rd_*  : read command to the bus (valid/ready, word-aligned addr)
//   bus_rsp_* : read data from the bus (valid only, no back-pressure)
//   rsp_*     : load result to the core (valid/ready, data, err)
// Modports:
//   slave  : the controller view
//   master : the environment view (core plus bus model)
// ---------------------------------------------------------------------------
interface rdload_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;

  logic        bus_rd_valid;
  logic        bus_rd_ready;
  logic [31:0] bus_rd_addr;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_addr, req_size, req_signed,
    output req_ready,
    output bus_rd_valid, bus_rd_addr,
    input  bus_rd_ready, bus_rsp_valid, bus_rsp_data,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_addr, req_size, req_signed,
    input  req_ready,
    input  bus_rd_valid, bus_rd_addr,
    output bus_rd_ready, bus_rsp_valid, bus_rsp_data,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/rdsel_ext.sv
// ---------------------------------------------------------------------------
// rdsel_ext
// Combinational lane select and extension of a 32-bit read word.
//   size      : access size (byte / half-word / word)
//   is_signed : 1 = sign-extend, 0 = zero-extend
//   lane      : byte offset addr[1:0] of the load
//   data      : raw read word from the bus
//   out       : extracted, extended result (0 for an illegal size)
// ---------------------------------------------------------------------------
module rdsel_ext
  import rdload_pkg::*;
(
  input  size_e       size,
  input  logic        is_signed,
  input  logic [1:0]  lane,
  input  logic [31:0] data,
  output logic [31:0] out
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte/half-word, then extend it to the full word.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    out    = 32'h0000_0000;

    case (lane)
      2'b00:   byte_s = data[7:0];
      2'b01:   byte_s = data[15:8];
      2'b10:   byte_s = data[23:16];
      2'b11:   byte_s = data[31:24];
      default: byte_s = 8'h00;
    endcase

    if (lane[1]) begin
      half_s = data[31:16];
    end else begin
      half_s = data[15:0];
    end

    case (size)
      SIZE_BYTE: out = {{24{is_signed & byte_s[7]}}, byte_s};
      SIZE_HALF: out = {{16{is_signed & half_s[15]}}, half_s};
      SIZE_WORD: out = data;
      default:   out = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/rdload_ctrl.sv
// ---------------------------------------------------------------------------
// rdload_ctrl
// Single-outstanding load controller. Accepts a load request, rejects
// misaligned/illegal ones immediately, otherwise issues one word-aligned bus
// read, waits up to TIMEOUT cycles for the data, extracts/extends the
// addressed lane and returns the result with an error flag.
// Ports:
//   clk  : clock, all state on the rising edge
//   srst : synchronous active-high reset
//   lif  : rdload_if.slave (request, bus read, bus response, result)
// Parameters:
//   TIMEOUT : max cycles spent in WAIT for a response (1..65535)
// ---------------------------------------------------------------------------
module rdload_ctrl
  import rdload_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic     clk,
  input  logic     srst,
  rdload_if.slave  lif
);

  localparam int                CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       lane_r;
  size_e            size_r;
  logic             signed_r;
  logic [31:0]      bus_rd_addr_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_data_r;
  logic             rsp_err_r;

  size_e            req_size_s;
  logic [31:0]      ext_data_s;

  assign req_size_s = size_e'(lif.req_size);

  // Extraction always works on the latched request attributes so the
  // captured result does not depend on what the core drives during WAIT.
  rdsel_ext u_rdsel_ext (
    .size      (size_r),
    .is_signed (signed_r),
    .lane      (lane_r),
    .data      (lif.bus_rsp_data),
    .out       (ext_data_s)
  );

  // Handshake readiness comes straight from the state register.
  assign lif.req_ready    = (state_r == ST_IDLE);
  assign lif.bus_rd_valid = (state_r == ST_ISSUE);

  assign lif.bus_rd_addr  = bus_rd_addr_r;
  assign lif.rsp_valid    = rsp_valid_r;
  assign lif.rsp_data     = rsp_data_r;
  assign lif.rsp_err      = rsp_err_r;

  // Controller FSM together with every registered output it owns.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      lane_r        <= 2'b00;
      size_r        <= SIZE_BYTE;
      signed_r      <= 1'b0;
      bus_rd_addr_r <= 32'h0000_0000;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= 32'h0000_0000;
      rsp_err_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (lif.req_valid) begin
            lane_r        <= lif.req_addr[1:0];
            size_r        <= req_size_s;
            signed_r      <= lif.req_signed;
            bus_rd_addr_r <= {lif.req_addr[31:2], 2'b00};
            if (req_is_bad(req_size_s, lif.req_addr[1:0])) begin
              // Rejected requests never reach the bus.
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_data_r  <= 32'h0000_0000;
            end else begin
              state_r     <= ST_ISSUE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          if (lif.bus_rd_ready) begin
            state_r <= ST_WAIT;
            cnt_r   <= '0;
          end else begin
            state_r <= ST_ISSUE;
          end
        end

        ST_WAIT: begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          // Response is tested first so it wins over a coincident timeout.
          if (lif.bus_rsp_valid) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= ext_data_s;
          end else if (cnt_r == CNT_LAST) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_data_r  <= 32'h0000_0000;
          end else begin
            state_r <= ST_WAIT;
          end
        end

        ST_RESP: begin
          if (lif.rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
          end else begin
            state_r <= ST_RESP;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rdload_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rdload_ctrl
// Directed scenarios followed by randomized loads for rdload_ctrl. Expected
// results come from ref_load, which derives the value with shift/mask
// arithmetic on the byte offset, and from the cycle timing rules of the
// controller (one ISSUE cycle per stalled bus_rd_ready, result one cycle
// after the response, timeout TIMEOUT cycles after entering WAIT).
// ---------------------------------------------------------------------------
module tb_rdload_ctrl;

  localparam int TIMEOUT = 4;

  logic clk;
  logic srst;
  int   n_checks;
  int   n_fail;

  rdload_if lif ();

  rdload_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .srst (srst),
    .lif  (lif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result: offset must be a multiple of the access width; the
  // selected field is (data >> 8*offset) masked to the width, then extended.
  function automatic void ref_load(input logic [31:0] addr, input logic [1:0] size,
                                   input logic sgn, input logic [31:0] data,
                                   output logic err, output logic [31:0] val);
    int          off;
    int          nbytes;
    logic [31:0] mask;
    off = int'(addr % 32'd4);
    err = 1'b0;
    val = 32'h0;
    case (size)
      2'd0:    nbytes = 1;
      2'd1:    nbytes = 2;
      2'd2:    nbytes = 4;
      default: nbytes = 0;
    endcase
    if (nbytes == 0 || (off % nbytes) != 0) begin
      err = 1'b1;
      return;
    end
    if (nbytes == 4) begin
      val = data;
    end else begin
      mask = (32'h1 << (8 * nbytes)) - 32'h1;
      val  = (data >> (8 * off)) & mask;
      if (sgn && val[8 * nbytes - 1]) val = val | ~mask;
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},    32'(lif.req_ready),    32'd1);
    chk({tag, "_bus_rd_valid"}, 32'(lif.bus_rd_valid), 32'd0);
    chk({tag, "_rsp_valid"},    32'(lif.rsp_valid),    32'd0);
    chk({tag, "_rsp_err"},      32'(lif.rsp_err),      32'd0);
    chk({tag, "_rsp_data"},     lif.rsp_data,          32'd0);
    chk({tag, "_bus_rd_addr"},  lif.bus_rd_addr,       32'd0);
  endtask

  // One complete load. rd_stall = cycles bus_rd_ready stays low,
  // rsp_dly = WAIT cycle index of the response (>= TIMEOUT means none),
  // out_stall = cycles rsp_ready stays low. Stray bus responses are driven
  // whenever the controller is not in WAIT.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] data,
                         input int rd_stall, input int rsp_dly, input int out_stall);
    logic        exp_err;
    logic [31:0] exp_data;
    int          n_wait;
    ref_load(addr, size, sgn, data, exp_err, exp_data);

    chk({tag, "_idle_ready"}, 32'(lif.req_ready), 32'd1);
    lif.req_valid  = 1'b1;
    lif.req_addr   = addr;
    lif.req_size   = size;
    lif.req_signed = sgn;
    tick();
    lif.req_valid  = 1'b0;
    lif.req_addr   = $urandom;
    lif.req_size   = 2'($urandom_range(0, 3));
    lif.req_signed = 1'($urandom_range(0, 1));

    if (!exp_err) begin
      for (int i = 0; i <= rd_stall; i++) begin
        chk({tag, "_bus_rd_valid"}, 32'(lif.bus_rd_valid), 32'd1);
        chk({tag, "_bus_rd_addr"},  lif.bus_rd_addr, {addr[31:2], 2'b00});
        chk({tag, "_busy_ready"},   32'(lif.req_ready), 32'd0);
        chk({tag, "_early_rsp"},    32'(lif.rsp_valid), 32'd0);
        lif.bus_rd_ready  = (i == rd_stall);
        lif.bus_rsp_valid = 1'($urandom_range(0, 1));
        lif.bus_rsp_data  = $urandom;
        tick();
      end
      lif.bus_rd_ready = 1'b0;
      n_wait = (rsp_dly >= TIMEOUT) ? TIMEOUT : rsp_dly + 1;
      for (int i = 0; i < n_wait; i++) begin
        chk({tag, "_wait_rd_valid"}, 32'(lif.bus_rd_valid), 32'd0);
        chk({tag, "_wait_rsp"},      32'(lif.rsp_valid), 32'd0);
        chk({tag, "_wait_ready"},    32'(lif.req_ready), 32'd0);
        lif.bus_rsp_valid = (i == rsp_dly);
        lif.bus_rsp_data  = (i == rsp_dly) ? data : $urandom;
        tick();
      end
      if (rsp_dly >= TIMEOUT) begin
        exp_err  = 1'b1;
        exp_data = 32'h0;
      end
    end

    for (int i = 0; i <= out_stall; i++) begin
      chk({tag, "_rsp_valid"},      32'(lif.rsp_valid), 32'd1);
      chk({tag, "_rsp_err"},        32'(lif.rsp_err), 32'(exp_err));
      chk({tag, "_rsp_data"},       lif.rsp_data, exp_data);
      chk({tag, "_resp_ready"},     32'(lif.req_ready), 32'd0);
      chk({tag, "_resp_rd_valid"},  32'(lif.bus_rd_valid), 32'd0);
      lif.rsp_ready     = (i == out_stall);
      lif.bus_rsp_valid = 1'($urandom_range(0, 1));
      lif.bus_rsp_data  = $urandom;
      tick();
    end
    lif.rsp_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(lif.rsp_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(lif.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r_addr;
    n_checks = 0;
    n_fail   = 0;
    srst              = 1'b1;
    lif.req_valid     = 1'b0;
    lif.req_addr      = 32'h0;
    lif.req_size      = 2'b00;
    lif.req_signed    = 1'b0;
    lif.bus_rd_ready  = 1'b0;
    lif.bus_rsp_valid = 1'b0;
    lif.bus_rsp_data  = 32'h0;
    lif.rsp_ready     = 1'b0;

    tick();
    tick();
    check_reset_outputs("reset");
    srst = 1'b0;

    // Byte loads, signed and unsigned, lane 3.
    do_load("byte_s", 32'h0000_1003, 2'b00, 1'b1, 32'h80FF_1234, 0, 0, 0);
    do_load("byte_u", 32'h0000_1003, 2'b00, 1'b0, 32'h80FF_1234, 0, 0, 0);
    // Upper half-word, signed.
    do_load("half_s", 32'h0000_2002, 2'b01, 1'b1, 32'h8001_7FFF, 0, 1, 0);
    // Misaligned word and illegal size: immediate error, no bus command.
    do_load("word_mis", 32'h0000_3002, 2'b10, 1'b0, 32'h1234_5678, 0, 0, 0);
    do_load("size_ill", 32'h0000_3000, 2'b11, 1'b1, 32'h1234_5678, 0, 0, 0);
    do_load("half_mis", 32'h0000_3001, 2'b01, 1'b0, 32'h1234_5678, 0, 0, 1);
    // Timeout with a late response during the stalled result, then recovery.
    do_load("timeout", 32'h0000_4000, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, 99, 3);
    do_load("after_to", 32'h0000_4004, 2'b10, 1'b0, 32'hCAFE_F00D, 0, 0, 0);
    // Response on the last WAIT cycle beats the timeout.
    do_load("rsp_wins", 32'h0000_4001, 2'b00, 1'b1, 32'h0000_7F00, 0, TIMEOUT - 1, 0);
    // Long command stall followed by a result stall.
    do_load("stall", 32'h0000_5006, 2'b01, 1'b0, 32'hA5A5_5A5A, 5, 2, 3);

    // Reset in the middle of WAIT.
    lif.req_valid  = 1'b1;
    lif.req_addr   = 32'h0000_6000;
    lif.req_size   = 2'b10;
    lif.req_signed = 1'b0;
    tick();
    lif.req_valid    = 1'b0;
    lif.bus_rd_ready = 1'b1;
    tick();
    lif.bus_rd_ready = 1'b0;
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check_reset_outputs("srst_wait");
    lif.bus_rsp_valid = 1'b1;
    lif.bus_rsp_data  = 32'h1111_2222;
    tick();
    lif.bus_rsp_valid = 1'b0;
    chk("srst_late_rsp_valid", 32'(lif.rsp_valid), 32'd0);
    chk("srst_late_rd_valid",  32'(lif.bus_rd_valid), 32'd0);
    chk("srst_late_ready",     32'(lif.req_ready), 32'd1);

    // Reset during ISSUE, then a request on the very first cycle after it.
    lif.req_valid = 1'b1;
    lif.req_addr  = 32'h0000_7000;
    lif.req_size  = 2'b10;
    tick();
    lif.req_valid = 1'b0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check_reset_outputs("srst_issue");
    do_load("first_after_srst", 32'h0000_7002, 2'b01, 1'b1, 32'hFFFE_0001, 0, 0, 0);

    // Randomized loads with random stalls, delays and idle gaps.
    for (int n = 0; n < 60; n++) begin
      r_addr = $urandom;
      do_load("rand", r_addr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT + 1)),
              int'($urandom_range(0, 3)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        lif.bus_rsp_valid = 1'($urandom_range(0, 1));
        lif.bus_rsp_data  = $urandom;
        tick();
        chk("gap_rsp_valid", 32'(lif.rsp_valid), 32'd0);
      end
      lif.bus_rsp_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rdload_ctrl.md
RDLOAD_CTRL -- requirements
Module: rdload_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum number of cycles spent waiting for a bus read response (legal range 1..65535).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 srst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  load request present.
REQ-005 req_ready  output  1  controller accepts a request; high only in IDLE.
REQ-006 req_addr  input  32  byte address of the load.
REQ-007 req_size  input  2  access size: 00 byte, 01 half-word, 10 word, 11 illegal.
REQ-008 req_signed  input  1  1 = sign-extend the result, 0 = zero-extend it.
REQ-009 bus_rd_valid  output  1  bus read command valid.
REQ-010 bus_rd_ready  input  1  bus accepts the command.
REQ-011 bus_rd_addr  output  32  word-aligned read address: {req_addr[31:2], 2'b00}.
REQ-012 bus_rsp_valid  input  1  read data valid; there is no back-pressure.
REQ-013 bus_rsp_data  input  32  read data word.
REQ-014 rsp_valid  output  1  load result valid.
REQ-015 rsp_ready  input  1  consumer accepts the result.
REQ-016 rsp_data  output  32  extracted and extended load result.
REQ-017 rsp_err  output  1  misaligned, illegal-size or timed-out load.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with IDLE as the reset state.
REQ-019 IDLE: on req_valid&&req_ready, the controller SHALL latch addr[1:0], size, signed and the aligned address. A legal, aligned request goes to ISSUE. Otherwise it goes to RESP with rsp_err=1 and rsp_data=0, and no bus command is issued.
REQ-020 Misaligned SHALL be defined as: half-word with addr[0]=1, or word with addr[1:0]!=00; size 11 is always illegal.
REQ-021 ISSUE: bus_rd_valid SHALL be 1, and bus_rd_addr SHALL stay stable until bus_rd_ready; on the handshake the FSM goes to WAIT and clears the timeout counter.
REQ-022 WAIT: the counter SHALL increment each cycle. On bus_rsp_valid, the FSM captures the extracted result, sets rsp_err=0 and goes to RESP.
REQ-023 If the counter reaches TIMEOUT-1 without bus_rsp_valid, the FSM SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-024 If bus_rsp_valid and the timeout occur in the same cycle, the response SHALL win (rsp_err=0).
REQ-025 Byte extraction SHALL use lane addr[1:0]; half-word extraction SHALL use the lower half if addr[1]=0, else the upper half. Word data passes unchanged. Byte and half-word results are extended to 32 bits per req_signed.
REQ-026 RESP: rsp_valid=1, and rsp_data/rsp_err SHALL stay stable until rsp_ready; on the handshake the FSM returns to IDLE.
REQ-027 bus_rsp_valid outside WAIT SHALL be ignored, including a late response after a timeout.
REQ-028 Latency (no stalls): accept at cycle 0, bus_rd_valid at cycle 1. A response at cycle N gives rsp_valid at cycle N+1, so the minimum accept-to-result time is 3 cycles. An error request gives rsp_valid at cycle 1.
REQ-029 Only one load SHALL be outstanding; req_ready=0 in ISSUE, WAIT and RESP.

Reset
REQ-030 srst SHALL force IDLE in any state, including mid-ISSUE or mid-WAIT. After reset: req_ready=1, bus_rd_valid=0, rsp_valid=0, rsp_err=0, rsp_data=0, bus_rd_addr=0, counter=0.
REQ-031 The first cycle after srst deasserts SHALL accept a request.

Structure
REQ-032 The size encodings (BYTE/HALF/WORD/ILLEGAL), the FSM state encodings and the counter width rule SHALL live in the shared package rdload_pkg. The counter width is clog2(TIMEOUT+1).
REQ-033 Extraction and extension SHALL be the combinational sub-module rdsel_ext, with inputs size, is_signed, lane[1:0], data[31:0] and output out[31:0].
REQ-034 All outputs SHALL be registered, except req_ready and bus_rd_valid, which are decoded from the state register only.

Verification
REQ-035 Scenario: byte load, addr=0x1003, signed=1, bus data 0x80FF_1234 -> rsp_data=0xFFFF_FF80, rsp_err=0. Repeat with signed=0 -> rsp_data=0x0000_0080.
REQ-036 Scenario: half-word load, addr=0x2002, signed=1, data 0x8001_7FFF -> rsp_data=0xFFFF_8001; bus_rd_addr=0x2000.
REQ-037 Scenario: word load at addr=0x3002 -> rsp_err=1 and rsp_data=0 at cycle 1; bus_rd_valid is never asserted. Repeat with size=11 and the same check.
REQ-038 Scenario: TIMEOUT=4 with no response -> rsp_err=1 exactly 4 cycles after entering WAIT. A bus_rsp_valid 2 cycles later is ignored, and the next load completes normally.
REQ-039 Scenario: bus_rd_ready held low 5 cycles, then rsp_ready held low 3 cycles -> bus_rd_addr stable throughout the stall, rsp_data stable throughout, req_ready=0 until the rsp handshake.
REQ-040 Scenario: srst asserted during WAIT -> next cycle all outputs are at reset values and req_ready=1. A bus response in the following cycle produces no rsp_valid.
